header_loader: RTL

- Host-side producer for the miner's 640-bit block header input.
- Accepts a byte stream from the host link receiver over a valid/ready handshake and assembles 80-byte headers, most significant byte first.
- Presents each completed header to the mining control block, holding it stable until that block acknowledges it.
- Double-buffered: the next header loads while the current one is still presented.

---
 rtl/header_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/header_loader.sv
// header_loader: assembles 80-byte block headers from a host byte stream
// and presents them to the mining control block. The shadow register
// collects the next header while the output slot presents the current
// one. A complete header that cannot be presented yet is held in the
// shadow until the slot frees up.
module header_loader #(
    parameter int HEADER_BYTES = 80,
    parameter int CNT_W        = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      abort,
    output logic [8*HEADER_BYTES-1:0] blockHeader,
    output logic                      header_valid,
    input  logic                      header_ack,
    output logic [6:0]                byte_count,
    output logic [CNT_W-1:0]          header_count
);

    localparam int HW = 8 * HEADER_BYTES;
    localparam logic [6:0] LAST_BYTE = 7'(HEADER_BYTES - 1);

    // LOADING: shadow is accepting bytes. HELD: shadow holds a complete
    // header waiting for the output slot.
    typedef enum logic [0:0] {
        LOADING = 1'b0,
        HELD    = 1'b1
    } loadState_t;

    loadState_t    stateR;
    logic [HW-1:0] shadowR;

    logic          acceptS;
    logic          freeS;
    logic          lastByteS;
    logic [HW-1:0] nextShadowS;

    // Handshake and slot decode; in_ready is a function of registered state only.
    always_comb begin
        in_ready    = (stateR == LOADING);
        acceptS     = in_valid & in_ready & ~abort;
        freeS       = ~header_valid | header_ack;
        lastByteS   = acceptS & (byte_count == LAST_BYTE);
        nextShadowS = {shadowR[HW-9:0], in_data};
    end

    // Shadow loading, output slot and load/hold state machine.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateR       <= LOADING;
            shadowR      <= '0;
            byte_count   <= 7'd0;
            blockHeader  <= '0;
            header_valid <= 1'b0;
            header_count <= '0;
        end else begin
            // Byte assembly. Abort discards only a partial header; a held
            // complete header in the shadow is left untouched.
            if (abort) begin
                byte_count <= 7'd0;
                if (stateR == LOADING) begin
                    shadowR <= '0;
                end else begin
                    shadowR <= shadowR;
                end
            end else if (acceptS) begin
                shadowR    <= nextShadowS;
                byte_count <= lastByteS ? 7'd0 : (byte_count + 7'd1);
            end else begin
                shadowR    <= shadowR;
                byte_count <= byte_count;
            end

            // Output slot. A transfer into a free slot takes priority over
            // a plain ack, so an ack coinciding with a transfer leaves
            // header_valid high with no idle cycle.
            case (stateR)
                LOADING: begin
                    if (lastByteS && freeS) begin
                        blockHeader  <= nextShadowS;
                        header_valid <= 1'b1;
                        header_count <= header_count + CNT_W'(1);
                    end else if (lastByteS) begin
                        stateR <= HELD;
                    end else if (header_valid && header_ack) begin
                        header_valid <= 1'b0;
                    end else begin
                        header_valid <= header_valid;
                    end
                end
                HELD: begin
                    if (freeS) begin
                        blockHeader  <= shadowR;
                        header_valid <= 1'b1;
                        header_count <= header_count + CNT_W'(1);
                        stateR       <= LOADING;
                    end else begin
                        stateR <= HELD;
                    end
                end
                default: begin
                    stateR <= LOADING;
                end
            endcase
        end
    end

endmodule
